// File: rtl/slide_move_gen.sv
// slide_move_gen: builds the legal-target mask for the piece on one square, testing one candidate square per SCAN cycle.
module slide_move_gen #(
    parameter int N  = 8,
    parameter int CW = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [CW-1:0]         row,
    input  logic [CW-1:0]         column,
    input  logic [N*N*5-1:0]      board,
    output logic                  ready,
    output logic                  done,
    output logic                  error,
    output logic [N*N-1:0]        move_mask,
    output logic [$clog2(N*N):0]  move_count
);
    localparam int MW = $clog2(N*N) + 1;
    typedef logic signed [CW:0] coord_t;
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    localparam logic [2:0] PAWN = 3'd1, KNIGHT = 3'd2, BISHOP = 3'd3, ROOK = 3'd4, KING = 3'd6;
    localparam coord_t CMAX = coord_t'(N - 1);
    localparam logic [CW:0] RMAX = (CW+1)'(N - 1);
    localparam logic [CW:0] ONE = (CW+1)'(1);
    localparam logic [CW:0] TWO = (CW+1)'(2);

    // Queen/king compass order N,NE,E,SE,S,SW,W,NW
    function automatic coord_t qdr(input logic [2:0] i);
        return (i == 3'd0 || i == 3'd1 || i == 3'd7) ? coord_t'(-1) :
               (i == 3'd2 || i == 3'd6) ? coord_t'(0) : coord_t'(1);
    endfunction

    function automatic coord_t qdc(input logic [2:0] i);
        return (i == 3'd0 || i == 3'd4) ? coord_t'(0) :
               (i == 3'd1 || i == 3'd2 || i == 3'd3) ? coord_t'(1) : coord_t'(-1);
    endfunction

    function automatic coord_t kdr(input logic [2:0] i);
        return (i == 3'd0 || i == 3'd7) ? coord_t'(-2) :
               (i == 3'd1 || i == 3'd6) ? coord_t'(-1) :
               (i == 3'd2 || i == 3'd5) ? coord_t'(1) : coord_t'(2);
    endfunction

    function automatic coord_t kdc(input logic [2:0] i);
        return (i == 3'd0 || i == 3'd3) ? coord_t'(1) :
               (i == 3'd1 || i == 3'd2) ? coord_t'(2) :
               (i == 3'd4 || i == 3'd7) ? coord_t'(-1) : coord_t'(-2);
    endfunction

    // Rook takes the even compass points, bishop NW,NE,SE,SW = 7,1,3,5
    function automatic logic [2:0] qidx(input logic [2:0] t, input logic [2:0] d);
        return t == ROOK ? {d[1:0], 1'b0} : t == BISHOP ? 3'({d[1:0], 1'b0} - 3'd1) : d;
    endfunction

    function automatic coord_t drow(input logic [2:0] t, input logic color, input logic [2:0] d);
        return t == PAWN ? (color ? coord_t'(1) : coord_t'(-1)) : t == KNIGHT ? kdr(d) : qdr(qidx(t, d));
    endfunction

    function automatic coord_t dcol(input logic [2:0] t, input logic [2:0] d);
        return t == PAWN ? (d == 3'd0 ? coord_t'(0) : d == 3'd1 ? coord_t'(-1) : coord_t'(1)) :
               t == KNIGHT ? kdc(d) : qdc(qidx(t, d));
    endfunction

    state_t        state;
    logic [CW-1:0] row_q, col_q;
    logic [2:0]    type_q, dir_q;
    logic          color_q, first_q;
    logic [CW:0]   step_q;
    coord_t        cr_q, cc_q;

    logic [4:0]    src_sq, cand_sq;
    logic [2:0]    ptype, dir_n;
    logic          mover, valid, off, next_off, is_pawn, set_bit, cont, last;
    coord_t        sr, sc, dr, dc, cr, cc, nr, nc;
    logic [CW:0]   rng;
    int            idx;

    always_comb begin
        src_sq   = board[(int'(row_q) * N + int'(col_q)) * 5 +: 5];
        ptype    = first_q ? src_sq[4:2] : type_q;
        mover    = first_q ? src_sq[1] : color_q;
        valid    = src_sq[0] && src_sq[4:2] != 3'd0 && src_sq[4:2] != 3'd7;
        is_pawn  = ptype == PAWN;
        sr       = coord_t'({1'b0, row_q});
        sc       = coord_t'({1'b0, col_q});
        dr       = drow(ptype, mover, dir_q);
        dc       = dcol(ptype, dir_q);
        cr       = first_q ? sr + dr : cr_q;
        cc       = first_q ? sc + dc : cc_q;
        off      = cr[CW] || cr > CMAX || cc[CW] || cc > CMAX;
        idx      = off ? 0 : int'(cr) * N + int'(cc);
        cand_sq  = board[idx * 5 +: 5];
        set_bit  = !off && (cand_sq[0] ? (cand_sq[1] != mover && !(is_pawn && dir_q == 3'd0))
                                       : !(is_pawn && dir_q != 3'd0));
        nr       = cr + dr;
        nc       = cc + dc;
        next_off = nr[CW] || nr > CMAX || nc[CW] || nc > CMAX;
        rng      = is_pawn ? ((dir_q == 3'd0 && row_q == (mover ? CW'(1) : CW'(N - 2))) ? TWO : ONE) :
                   (ptype == KNIGHT || ptype == KING) ? ONE : RMAX;
        cont     = !off && !cand_sq[0] && !next_off && step_q < rng;
        last     = dir_q == (is_pawn ? 3'd2 : (ptype == ROOK || ptype == BISHOP) ? 3'd3 : 3'd7);
        dir_n    = dir_q + 3'd1;
        ready    = state == IDLE;
        done     = state == DONE;
        move_count = '0;
        for (int i = 0; i < N*N; i++)
            move_count = move_count + MW'(move_mask[i]);
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state     <= IDLE;
            row_q     <= '0;
            col_q     <= '0;
            type_q    <= '0;
            color_q   <= 1'b0;
            dir_q     <= '0;
            step_q    <= '0;
            first_q   <= 1'b0;
            cr_q      <= '0;
            cc_q      <= '0;
            error     <= 1'b0;
            move_mask <= '0;
        end else
            case (state)
                IDLE: if (start) begin
                    row_q     <= row;
                    col_q     <= column;
                    move_mask <= '0;
                    error     <= 1'b0;
                    dir_q     <= '0;
                    step_q    <= ONE;
                    first_q   <= 1'b1;
                    state     <= SCAN;
                end
                SCAN: begin
                    first_q <= 1'b0;
                    type_q  <= ptype;
                    color_q <= mover;
                    if (first_q && !valid) begin
                        error <= 1'b1;
                        state <= DONE;
                    end else begin
                        if (set_bit) move_mask[idx] <= 1'b1;
                        if (cont) begin
                            cr_q   <= nr;
                            cc_q   <= nc;
                            step_q <= step_q + ONE;
                        end else if (last)
                            state <= DONE;
                        else begin
                            dir_q  <= dir_n;
                            step_q <= ONE;
                            cr_q   <= sr + drow(ptype, mover, dir_n);
                            cc_q   <= sc + dcol(ptype, dir_n);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
endmodule

// File: tb/tb_slide_move_gen.sv
// tb_slide_move_gen: directed scenarios on an 8x8 and a 4x4 instance with hand-computed masks.
module tb_slide_move_gen;
    logic         clk = 1'b0, reset_n = 1'b0, start8 = 1'b0, start4 = 1'b0;
    logic [2:0]   row8 = '0, col8 = '0;
    logic [1:0]   row4 = '0, col4 = '0;
    logic [319:0] board8 = '0;
    logic [79:0]  board4 = '0;
    logic         ready8, done8, error8, ready4, done4, error4;
    logic [63:0]  mask8;
    logic [6:0]   cnt8;
    logic [15:0]  mask4;
    logic [4:0]   cnt4;
    int vectors = 0, errors = 0;

    always #5 clk = ~clk;

    slide_move_gen #(.N(8)) dut8 (.clk(clk), .reset_n(reset_n), .start(start8), .row(row8), .column(col8),
        .board(board8), .ready(ready8), .done(done8), .error(error8), .move_mask(mask8), .move_count(cnt8));
    slide_move_gen #(.N(4)) dut4 (.clk(clk), .reset_n(reset_n), .start(start4), .row(row4), .column(col4),
        .board(board4), .ready(ready4), .done(done4), .error(error4), .move_mask(mask4), .move_count(cnt4));

    task automatic put8(input int r, input int c, input logic [4:0] v);
        board8[(r*8+c)*5 +: 5] = v;
    endtask

    // Returns the number of SCAN cycles before done, or -1 on timeout; rp re-pulses start at that cycle
    task automatic run8(input int r, input int c, input int rp, output int cyc);
        if (!ready8) begin @(posedge clk); #1; end
        row8 = 3'(r); col8 = 3'(c);
        @(negedge clk); start8 = 1'b1;
        @(posedge clk); #1; start8 = 1'b0;
        cyc = 0;
        while (!done8 && cyc < 200) begin
            if (cyc == rp) start8 = 1'b1;
            @(posedge clk); #1; start8 = 1'b0;
            cyc++;
        end
        if (!done8) cyc = -1;
    endtask

    task automatic test_reset;
        #12;
        vectors += 5;
        if (ready8 !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready8); end
        if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done8); end
        if (error8 !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", error8); end
        if (mask8 !== 64'd0) begin errors++; $display("FAIL reset_mask: got %h expected 0", mask8); end
        if (cnt8 !== 7'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", cnt8); end
        @(posedge clk); #2 reset_n = 1'b1;
    endtask

    task automatic test_rook;
        int cyc;
        board8 = '0; put8(0, 0, 5'b10001);
        run8(0, 0, -1, cyc);
        vectors += 7;
        if (cyc !== 16) begin errors++; $display("FAIL rook_cycles: got %0d expected 16", cyc); end
        if (mask8 !== 64'h01010101010101FE) begin errors++; $display("FAIL rook_mask: got %h expected 01010101010101fe", mask8); end
        if (cnt8 !== 7'd14) begin errors++; $display("FAIL rook_count: got %0d expected 14", cnt8); end
        if (error8 !== 1'b0) begin errors++; $display("FAIL rook_error: got %b expected 0", error8); end
        @(posedge clk); #1;
        if (ready8 !== 1'b1) begin errors++; $display("FAIL rook_ready_after: got %b expected 1", ready8); end
        if (done8 !== 1'b0) begin errors++; $display("FAIL rook_done_width: got %b expected 0", done8); end
        if (mask8 !== 64'h01010101010101FE) begin errors++; $display("FAIL rook_mask_held: got %h expected 01010101010101fe", mask8); end
    endtask

    task automatic test_pawn;
        int cyc;
        logic [63:0] exp;
        board8 = '0; put8(6, 4, 5'b00101); put8(5, 3, 5'b01011);
        exp = (64'd1 << 44) | (64'd1 << 36) | (64'd1 << 43);
        run8(6, 4, -1, cyc);
        vectors += 3;
        if (cyc !== 4) begin errors++; $display("FAIL pawn_cycles: got %0d expected 4", cyc); end
        if (mask8 !== exp) begin errors++; $display("FAIL pawn_mask: got %h expected %h", mask8, exp); end
        if (cnt8 !== 7'd3) begin errors++; $display("FAIL pawn_count: got %0d expected 3", cnt8); end
    endtask

    task automatic test_error;
        int cyc;
        board8 = '0; put8(0, 0, 5'b10001);
        run8(3, 3, -1, cyc);
        vectors += 4;
        if (cyc !== 1) begin errors++; $display("FAIL empty_cycles: got %0d expected 1", cyc); end
        if (error8 !== 1'b1) begin errors++; $display("FAIL empty_error: got %b expected 1", error8); end
        if (mask8 !== 64'd0) begin errors++; $display("FAIL empty_mask: got %h expected 0", mask8); end
        if (cnt8 !== 7'd0) begin errors++; $display("FAIL empty_count: got %0d expected 0", cnt8); end
        put8(3, 3, 5'b11101);
        run8(3, 3, -1, cyc);
        vectors += 2;
        if (cyc !== 1) begin errors++; $display("FAIL type7_cycles: got %0d expected 1", cyc); end
        if (error8 !== 1'b1) begin errors++; $display("FAIL type7_error: got %b expected 1", error8); end
    endtask

    task automatic test_knight;
        int cyc;
        logic [63:0] exp;
        board8 = '0; put8(0, 1, 5'b01011); put8(2, 2, 5'b00101); put8(2, 0, 5'b00111);
        exp = (64'd1 << 18) | (64'd1 << 11);
        run8(0, 1, -1, cyc);
        vectors += 4;
        if (cyc !== 8) begin errors++; $display("FAIL knight_cycles: got %0d expected 8", cyc); end
        if (mask8 !== exp) begin errors++; $display("FAIL knight_mask: got %h expected %h", mask8, exp); end
        if (cnt8 !== 7'd2) begin errors++; $display("FAIL knight_count: got %0d expected 2", cnt8); end
        if (error8 !== 1'b0) begin errors++; $display("FAIL knight_error_cleared: got %b expected 0", error8); end
    endtask

    task automatic test_queen_repulse;
        int cyc;
        logic [63:0] exp;
        board8 = '0; put8(3, 3, 5'b10101);
        exp = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                if (!(r == 3 && c == 3) && (r == 3 || c == 3 || r == c || r + c == 6)) exp[r*8+c] = 1'b1;
        run8(3, 3, 5, cyc);
        vectors += 3;
        if (cyc !== 27) begin errors++; $display("FAIL queen_cycles: got %0d expected 27", cyc); end
        if (mask8 !== exp) begin errors++; $display("FAIL queen_mask: got %h expected %h", mask8, exp); end
        if (cnt8 !== 7'd27) begin errors++; $display("FAIL queen_count: got %0d expected 27", cnt8); end
    endtask

    task automatic test_reset_midscan;
        logic [63:0] exp;
        bit seen;
        exp = (64'd1 << 3) | (64'd1 << 11) | (64'd1 << 19) | (64'd1 << 20);
        if (!ready8) begin @(posedge clk); #1; end
        row8 = 3'd3; col8 = 3'd3;
        @(negedge clk); start8 = 1'b1;
        @(posedge clk); #1; start8 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        vectors += 2;
        if (ready8 !== 1'b0) begin errors++; $display("FAIL mid_ready: got %b expected 0", ready8); end
        if (mask8 !== exp) begin errors++; $display("FAIL mid_mask: got %h expected %h", mask8, exp); end
        #2 reset_n = 1'b0;
        #1;
        vectors += 5;
        if (ready8 !== 1'b1) begin errors++; $display("FAIL arst_ready: got %b expected 1", ready8); end
        if (done8 !== 1'b0) begin errors++; $display("FAIL arst_done: got %b expected 0", done8); end
        if (error8 !== 1'b0) begin errors++; $display("FAIL arst_error: got %b expected 0", error8); end
        if (mask8 !== 64'd0) begin errors++; $display("FAIL arst_mask: got %h expected 0", mask8); end
        if (cnt8 !== 7'd0) begin errors++; $display("FAIL arst_count: got %0d expected 0", cnt8); end
        @(negedge clk); reset_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (done8) seen = 1'b1; end
        vectors += 2;
        if (seen !== 1'b0) begin errors++; $display("FAIL arst_no_done: got %b expected 0", seen); end
        if (ready8 !== 1'b1) begin errors++; $display("FAIL arst_idle: got %b expected 1", ready8); end
    endtask

    task automatic test_n4_bishop;
        int cyc;
        board4 = '0; board4[(1*4+1)*5 +: 5] = 5'b01101;
        row4 = 2'd1; col4 = 2'd1;
        @(negedge clk); start4 = 1'b1;
        @(posedge clk); #1; start4 = 1'b0;
        cyc = 0;
        while (!done4 && cyc < 200) begin @(posedge clk); #1; cyc++; end
        if (!done4) cyc = -1;
        vectors += 3;
        if (cyc !== 5) begin errors++; $display("FAIL n4_cycles: got %0d expected 5", cyc); end
        if (mask4 !== 16'b1000_0101_0000_0101) begin errors++; $display("FAIL n4_mask: got %b expected 1000010100000101", mask4); end
        if (cnt4 !== 5'd5) begin errors++; $display("FAIL n4_count: got %0d expected 5", cnt4); end
    endtask

    initial begin
        test_reset;
        test_rook;
        test_pawn;
        test_error;
        test_knight;
        test_queen_repulse;
        test_reset_midscan;
        test_n4_bishop;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
